// File: rtl/if_fetch_stage_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage
package if_pkg;
  localparam int INS_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory ready/valid port (master = fetch stage)
interface if_fetch_stage_if;
  import if_pkg::*;
  logic req;
  logic [31:0] addr;
  logic ready;
  logic rvalid;
  logic [INS_W-1:0] rdata;
  modport master(output req, addr, input ready, rvalid, rdata);
  modport slave(input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush over freeze over load/bubble
module if_id_reg
  import if_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             load,
  input  logic [INS_W-1:0] next_ins,
  input  logic [31:0]      next_pc,
  output logic [INS_W-1:0] ins,
  output logic [31:0]      pc,
  output logic             valid
);
  // flush kills the slot, freeze holds everything, otherwise load or bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ins   <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!freeze) begin
      valid <= load;
      if (load) begin
        ins <= next_ins;
        pc  <= next_pc;
      end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, single-outstanding imem fetch, skid buffer, IF/ID output; IF_PERF_CNT_EN adds fetch/squash counters
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard,
  input  logic                  Branch_taken,
  input  logic [31:0]           Branch_Address,
  if_fetch_stage_if.master      imem,
  output logic [INS_W-1:0]      Ins,
  output logic [31:0]           PC,
  output logic                  valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           squash_cnt
`endif
);
  state_t state;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [INS_W-1:0] skid_q;
  logic load;
  assign pc_next   = pc_q + PC_INC;
  assign imem.req  = state == FETCH;
  assign imem.addr = pc_q;
  assign load = !Branch_taken && !hazard && ((state == WAIT && imem.rvalid) || state == HOLD);
  // fetch FSM: one outstanding request, redirect on branch, park data in skid under hazard
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= FETCH;
      pc_q   <= RESET_PC;
      skid_q <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (Branch_taken) pc_q <= Branch_Address;
          if (imem.ready) state <= Branch_taken ? DROP : WAIT;
        end
        WAIT: begin
          if (Branch_taken) begin
            pc_q  <= Branch_Address;
            state <= imem.rvalid ? FETCH : DROP;
          end else if (imem.rvalid && hazard) begin
            skid_q <= imem.rdata;
            state  <= HOLD;
          end else if (imem.rvalid) begin
            pc_q  <= pc_next;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (Branch_taken) begin
            pc_q  <= Branch_Address;
            state <= FETCH;
          end else if (!hazard) begin
            pc_q  <= pc_next;
            state <= FETCH;
          end
        end
        DROP: begin
          if (Branch_taken) pc_q <= Branch_Address;
          if (imem.rvalid) state <= FETCH;
        end
      endcase
    end
  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (Branch_taken),
    .freeze   (hazard),
    .load     (load),
    .next_ins (state == HOLD ? skid_q : imem.rdata),
    .next_pc  (pc_next),
    .ins      (Ins),
    .pc       (PC),
    .valid    (valid)
  );
`ifdef IF_PERF_CNT_EN
  logic squash;
  assign squash = (state == WAIT && imem.rvalid && Branch_taken) ||
                  (state == HOLD && Branch_taken) ||
                  (state == DROP && imem.rvalid);
  // count delivered instructions and branch-discarded responses/skid entries
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (load) fetch_cnt <= fetch_cnt + 32'd1;
      if (squash) squash_cnt <= squash_cnt + 32'd1;
    end
`endif
endmodule
